serial_adder: RTL
=================

// Module: serial_adder
// PURPOSE
//   Parametrised multi-bit add/subtract unit; digit-serial successor of half_adder.
//   Processes DIGIT bits per clock through a chain of full_adder cells, with carry held in a flop.
//   Sits between an operand producer and a result consumer.
//   Uses valid/ready handshakes on both sides.
// PARAMETERS
//   WIDTH  16  operand and sum width in bits; WIDTH >= 2
//   DIGIT  1   bits processed per cycle; WIDTH % DIGIT == 0 or elaboration fails
// PORTS
//   iCLK    in   1      single clock, rising edge
//   iRST_N  in   1      asynchronous, active-low reset
//   iVALID  in   1      operands valid
//   oREADY  out  1      unit idle, operands accepted this cycle
//   iA      in   WIDTH  operand A
//   iB      in   WIDTH  operand B
//   iCIN    in   1      carry in (add mode only)
//   iSUB    in   1      1 = compute A - B (iCIN ignored)
//   oVALID  out  1      result valid, held until consumed
//   iREADY  in   1      consumer accepts result
//   oSUM    out  WIDTH  sum / difference
//   oCARRY  out  1      unsigned carry out (sub: 1 = no borrow)
//   oOVF    out  1      two's-complement overflow
// BEHAVIOUR
//   Reset (async assert, sync release): state IDLE, oREADY=1, oVALID=0, oSUM=0, oCARRY=0, oOVF=0.
//   States and steps:
//     STEPS = WIDTH/DIGIT.
//     FSM states: IDLE -> RUN -> DONE -> IDLE.
//   IDLE:
//     oREADY=1.
//     On iVALID&&oREADY, capture A and B into shift registers; B is captured as ~iB if iSUB.
//     Carry flop <= iSUB ? 1 : iCIN. Step counter <= 0. Next state is RUN.
//   RUN:
//     oREADY=0.
//     Each cycle, add the low DIGIT bits of A and B plus the carry flop.
//     Shift operands right by DIGIT. Shift the digit sum into the sum register from the MSB end.
//     Carry flop <= chain carry out. Counter increments.
//     On counter==STEPS-1, latch oCARRY = chain carry out.
//     Also latch oOVF = (carry into MSB cell) ^ (chain carry out). Next state is DONE.
//   DONE:
//     oVALID=1. oSUM, oCARRY and oOVF are stable and held while iREADY=0.
//     On oVALID&&iREADY, go to IDLE: oVALID=0 and oREADY=1 from the next cycle.
//   Latency: oVALID rises STEPS cycles after the accept edge.
//     Minimum issue interval is STEPS+2 cycles.
//     No accept in the same cycle as result handoff.
//   Inputs iA, iB, iCIN and iSUB are ignored outside the accept cycle.
//     iVALID while busy is ignored, not queued.
//   DIGIT==WIDTH: single RUN cycle; behaviour is otherwise identical.
//   Arithmetic is modulo 2^WIDTH. oOVF is valid for both add and sub.
//   Reset mid-RUN or mid-DONE: immediate abort to reset values. No partial result is ever presented.
// STRUCTURE
//   adder_pkg:
//     state encoding localparams ST_IDLE, ST_RUN, ST_DONE (2-bit).
//     Counter-width function clog2.
//   Sub-module full_adder (iA, iB, iCIN -> oSUM, oCARRY), instantiated DIGIT times in a generate chain.
//   Top level holds the FSM, counter, operand/sum shift registers, and carry and flag flops.
// TESTING (WIDTH=8 unless noted; self-checking bench against a behavioural model)
//   1. Reset, then A=8'h0F, B=8'h01, add, CIN=0, DIGIT=1.
//      -> oVALID high 8 cycles after accept; oSUM=8'h10, oCARRY=0, oOVF=0.
//   2. Add 8'hFF+8'h01 -> 8'h00, carry=1, ovf=0.
//      Add 8'h7F+8'h01 -> 8'h80, carry=0, ovf=1.
//      Add 8'h00+8'h00 with CIN=1 -> 8'h01.
//   3. Sub 8'h05-8'h07 -> 8'hFE, carry=0, ovf=0.
//      Sub 8'h80-8'h01 -> 8'h7F, carry=1, ovf=1.
//   4. Hold iREADY=0 for 5 cycles after oVALID, and pulse iVALID with new operands during that window.
//      -> oVALID and oSUM held, oREADY=0, new operands dropped.
//      After the iREADY handshake, oREADY=1 next cycle.
//   5. Assert iRST_N=0 for 1 cycle after the third RUN cycle.
//      -> all outputs take reset values asynchronously.
//      Next op 8'h12+8'h34 yields 8'h46.
//   6. DIGIT=4 and DIGIT=8, 1000 random add/sub ops with random iREADY stalls.
//      -> latency is 2 and 1 respectively; all results and flags match the model.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared FSM encoding and elaboration helpers for the digit-serial add/subtract unit.
package adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bits needed to count 0..value-1; only used at elaboration time.
  function automatic int clog2(input int value);
    int bits;
    bits = 0;
    for (int v = value - 1; v > 0; v = v >>> 1) begin
      bits = bits + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; chained DIGIT times by the serial adder.
module full_adder (
  input  logic iA,
  input  logic iB,
  input  logic iCIN,
  output logic oSUM,
  output logic oCARRY
);

  assign oSUM   = iA ^ iB ^ iCIN;
  assign oCARRY = (iA & iB) | (iCIN & (iA ^ iB));

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/subtract unit: WIDTH/DIGIT steps through a full-adder chain,
// with valid/ready handshakes on the operand and result sides.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iVALID,
  output logic             oREADY,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iCIN,
  input  logic             iSUB,
  output logic             oVALID,
  input  logic             iREADY,
  output logic [WIDTH-1:0] oSUM,
  output logic             oCARRY,
  output logic             oOVF
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (clog2(STEPS) < 1) ? 1 : clog2(STEPS);
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic             ready_r;
  logic             ready_nxt_s;
  logic             valid_r;
  logic             valid_nxt_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] sum_out_r;
  logic             carry_out_r;
  logic             ovf_r;

  logic [DIGIT:0]   chain_c_s;
  logic [DIGIT-1:0] digit_sum_s;
  logic [WIDTH-1:0] sum_shift_s;
  logic             accept_s;
  logic             last_s;
  logic             handoff_s;

  assign accept_s  = ready_r & iVALID;
  assign last_s    = (state_r == ST_RUN) && (cnt_r == LAST_STEP);
  assign handoff_s = valid_r & iREADY;

  assign chain_c_s[0] = carry_r;

  generate
    for (genvar i = 0; i < DIGIT; i++) begin : g_chain
      full_adder u_fa (
        .iA     (a_r[i]),
        .iB     (b_r[i]),
        .iCIN   (chain_c_s[i]),
        .oSUM   (digit_sum_s[i]),
        .oCARRY (chain_c_s[i+1])
      );
    end

    // New digits enter at the MSB end so the word is complete after the last step.
    if (DIGIT == WIDTH) begin : g_full_digit
      assign sum_shift_s = digit_sum_s;
    end else begin : g_part_digit
      assign sum_shift_s = {digit_sum_s, sum_r[WIDTH-1:DIGIT]};
    end
  endgenerate

  // State register and registered handshake flags
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= ready_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_RUN;
        else          state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_s) state_nxt_s = ST_DONE;
        else        state_nxt_s = ST_RUN;
      end
      ST_DONE: begin
        if (handoff_s) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Handshake flags for the upcoming state, registered above
  always_comb begin
    ready_nxt_s = 1'b0;
    valid_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_IDLE: ready_nxt_s = 1'b1;
      ST_RUN:  ready_nxt_s = 1'b0;
      ST_DONE: valid_nxt_s = 1'b1;
      default: begin
        ready_nxt_s = 1'b0;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Operand capture, serial stepping and result latch
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      sum_r       <= {WIDTH{1'b0}};
      carry_r     <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      sum_out_r   <= {WIDTH{1'b0}};
      carry_out_r <= 1'b0;
      ovf_r       <= 1'b0;
    end else if (accept_s) begin
      a_r     <= iA;
      b_r     <= iSUB ? ~iB : iB;
      carry_r <= iSUB ? 1'b1 : iCIN;
      cnt_r   <= {CW{1'b0}};
    end else if (state_r == ST_RUN) begin
      a_r     <= a_r >> DIGIT;
      b_r     <= b_r >> DIGIT;
      sum_r   <= sum_shift_s;
      carry_r <= chain_c_s[DIGIT];
      cnt_r   <= cnt_r + CNT_ONE;
      if (last_s) begin
        sum_out_r   <= sum_shift_s;
        carry_out_r <= chain_c_s[DIGIT];
        // Carry into the sign cell differs from carry out exactly on signed overflow.
        ovf_r       <= chain_c_s[DIGIT-1] ^ chain_c_s[DIGIT];
      end
    end
  end

  assign oREADY = ready_r;
  assign oVALID = valid_r;
  assign oSUM   = sum_out_r;
  assign oCARRY = carry_out_r;
  assign oOVF   = ovf_r;

endmodule
